// File: rtl/aibnd_txdrv_seq.sv
// aibnd_txdrv_seq: break-before-make sequencer for the TX driver segment enables and weak pulls.
// Active legs ramp one segment per step tick, and the weak pull changes only while both legs are at zero.
module aibnd_txdrv_seq #(
    parameter int NSEG = 16
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            cfg_req,
    input  logic [1:0]      cfg_mode,
    input  logic [4:0]      cfg_pstr,
    input  logic [4:0]      cfg_nstr,
    input  logic [3:0]      step_div,
    output logic [NSEG-1:0] pdrv_en,
    output logic [NSEG-1:0] ndrv_enb,
    output logic            weak_pulldownen,
    output logic            weak_pullupenb,
    output logic            busy,
    output logic            cfg_ack
);
    localparam int CW = $clog2(NSEG + 1);
    localparam logic [2:0] IDLE = 3'd0, RAMP1 = 3'd1, WEAK = 3'd2, RAMP2 = 3'd3, DONE = 3'd4;
    localparam logic [1:0] WK_HIZ = 2'b01, WK_PD = 2'b11, WK_PU = 2'b00;

    logic [2:0]    st_q, st_d;
    logic [1:0]    mode_q, mode_d, nmode_q, wk_q, wk_d;
    logic [CW-1:0] ptgt_q, ntgt_q, pcnt_q, pcnt_d, ncnt_q, ncnt_d, r1p, r1n;
    logic [3:0]    div_q, cnt_q;
    logic          tick, cap;

    function automatic logic [CW-1:0] sat(input logic [4:0] x);
        return (int'(x) > NSEG) ? CW'(NSEG) : CW'(x);
    endfunction

    function automatic logic [CW-1:0] step(input logic [CW-1:0] c, input logic [CW-1:0] t);
        return (c < t) ? c + 1'b1 : (c > t) ? c - 1'b1 : c;
    endfunction

    function automatic logic [1:0] wk_code(input logic [1:0] m);
        return (m == 2'b01) ? WK_PD : (m == 2'b10) ? WK_PU : WK_HIZ;
    endfunction

    assign tick = cnt_q == div_q;
    assign cap  = (st_q == IDLE) && cfg_req;
    // A drive-to-drive change ramps straight to the new strengths; anything else first drains to zero.
    assign r1p  = (mode_q == 2'b11 && nmode_q == 2'b11) ? ptgt_q : '0;
    assign r1n  = (mode_q == 2'b11 && nmode_q == 2'b11) ? ntgt_q : '0;

    always_comb begin
        st_d   = st_q;
        mode_d = mode_q;
        wk_d   = wk_q;
        pcnt_d = pcnt_q;
        ncnt_d = ncnt_q;
        case (st_q)
            IDLE: st_d = cfg_req ? RAMP1 : IDLE;
            RAMP1: begin
                if (pcnt_q == r1p && ncnt_q == r1n) begin
                    st_d = WEAK;
                    wk_d = wk_code(nmode_q);
                end else if (tick) begin
                    pcnt_d = step(pcnt_q, r1p);
                    ncnt_d = step(ncnt_q, r1n);
                end
            end
            WEAK: st_d = tick ? RAMP2 : WEAK;
            RAMP2: begin
                if (pcnt_q == ptgt_q && ncnt_q == ntgt_q) begin
                    st_d = DONE;
                end else if (tick) begin
                    pcnt_d = step(pcnt_q, ptgt_q);
                    ncnt_d = step(ncnt_q, ntgt_q);
                end
            end
            DONE: begin
                st_d   = IDLE;
                mode_d = nmode_q;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            st_q    <= IDLE;
            mode_q  <= 2'b01;
            nmode_q <= 2'b01;
            ptgt_q  <= '0;
            ntgt_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            ncnt_q  <= '0;
            wk_q    <= WK_PD;
        end else begin
            st_q   <= st_d;
            mode_q <= mode_d;
            wk_q   <= wk_d;
            pcnt_q <= pcnt_d;
            ncnt_q <= ncnt_d;
            cnt_q  <= (st_d != st_q || tick) ? '0 : cnt_q + 1'b1;
            if (cap) begin
                nmode_q <= cfg_mode;
                ptgt_q  <= (cfg_mode == 2'b11) ? sat(cfg_pstr) : '0;
                ntgt_q  <= (cfg_mode == 2'b11) ? sat(cfg_nstr) : '0;
                div_q   <= step_div;
            end
        end
    end

    for (genvar i = 0; i < NSEG; i++) begin : g_therm
        assign pdrv_en[i]  = pcnt_q > CW'(i);
        assign ndrv_enb[i] = ncnt_q <= CW'(i);
    end

    assign {weak_pulldownen, weak_pullupenb} = wk_q;
    assign busy    = st_q != IDLE;
    assign cfg_ack = st_q == DONE;
endmodule

// File: tb/tb_aibnd_txdrv_seq.sv
// tb_aibnd_txdrv_seq: directed vectors for aibnd_txdrv_seq with hand-computed expectations.
// A per-cycle monitor also checks break-before-make and single-segment steps on every cycle.
module tb_aibnd_txdrv_seq;
    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        cfg_req = 1'b0;
    logic [1:0]  cfg_mode = 2'b00;
    logic [4:0]  cfg_pstr = 5'd0;
    logic [4:0]  cfg_nstr = 5'd0;
    logic [3:0]  step_div = 4'd0;
    logic [15:0] pdrv_en, ndrv_enb;
    logic        weak_pulldownen, weak_pullupenb, busy, cfg_ack;

    int n_vec = 0;
    int n_err = 0;
    int n_ack = 0;
    int prev_p = 0;
    int prev_n = 0;
    bit prev_ok = 0;

    aibnd_txdrv_seq #(.NSEG(16)) dut (
        .clk(clk), .rstb(rstb), .cfg_req(cfg_req), .cfg_mode(cfg_mode),
        .cfg_pstr(cfg_pstr), .cfg_nstr(cfg_nstr), .step_div(step_div),
        .pdrv_en(pdrv_en), .ndrv_enb(ndrv_enb), .weak_pulldownen(weak_pulldownen),
        .weak_pullupenb(weak_pullupenb), .busy(busy), .cfg_ack(cfg_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic req(input logic [1:0] m, input logic [4:0] p, input logic [4:0] n, input logic [3:0] d);
        cfg_mode = m;
        cfg_pstr = p;
        cfg_nstr = n;
        step_div = d;
        cfg_req  = 1'b1;
    endtask

    task automatic wait_ack(input string tag, input int budget);
        for (int i = 0; i < budget && !cfg_ack; i++) cyc();
        chk(tag, 32'(cfg_ack), 32'd1);
    endtask

    // Break-before-make and one-segment-per-cycle monitor.
    always @(negedge clk) begin
        if (rstb) begin
            chk("bbm", 32'({weak_pulldownen, weak_pullupenb} == 2'b10 ||
                ({weak_pulldownen, weak_pullupenb} != 2'b01 && (pdrv_en != 16'h0 || ndrv_enb != 16'hFFFF))), 32'd0);
            if (prev_ok)
                chk("step", 32'(($countones(pdrv_en) - prev_p > 1) || (prev_p - $countones(pdrv_en) > 1) ||
                    ($countones(~ndrv_enb) - prev_n > 1) || (prev_n - $countones(~ndrv_enb) > 1)), 32'd0);
            prev_p  = $countones(pdrv_en);
            prev_n  = $countones(~ndrv_enb);
            prev_ok = 1;
            if (cfg_ack) n_ack++;
        end else begin
            prev_ok = 0;
        end
    end

    initial begin
        repeat (2) cyc();
        chk("rst_p", 32'(pdrv_en), 32'h0);
        chk("rst_n", 32'(ndrv_enb), 32'hFFFF);
        chk("rst_wk", 32'({weak_pulldownen, weak_pullupenb}), 32'h3);
        chk("rst_busy", 32'({busy, cfg_ack}), 32'h0);

        // Request presented at reset release; accepted on the first edge.
        rstb = 1'b1;
        req(2'b11, 5'd4, 5'd3, 4'd0);
        cyc();
        chk("t1_busy", 32'(busy), 32'd1);
        cfg_req = 1'b0;
        cyc();
        chk("t1_weak", 32'({weak_pulldownen, weak_pullupenb}), 32'h1);
        chk("t1_p0", 32'(pdrv_en), 32'h0);
        cyc();
        chk("t1_p0b", 32'(pdrv_en), 32'h0);
        cyc();
        chk("t1_p1", 32'(pdrv_en), 32'h1);
        cyc();
        chk("t1_p3", 32'(pdrv_en), 32'h3);
        cyc();
        chk("t1_p7", 32'(pdrv_en), 32'h7);
        cyc();
        chk("t1_pF", 32'(pdrv_en), 32'hF);
        chk("t1_n", 32'(ndrv_enb), 32'hFFF8);
        cyc();
        chk("t1_ack", 32'({busy, cfg_ack}), 32'h3);
        cyc();
        chk("t1_idle", 32'({busy, cfg_ack}), 32'h0);
        chk("t1_nack", 32'(n_ack), 32'd1);

        // Drive-to-drive ramp, one step every 4 cycles.
        req(2'b11, 5'd2, 5'd6, 4'd3);
        cyc();
        cfg_req = 1'b0;
        repeat (3) cyc();
        chk("t2_hold", 32'(pdrv_en), 32'hF);
        cyc();
        chk("t2_s1p", 32'(pdrv_en), 32'h7);
        chk("t2_s1n", 32'(ndrv_enb), 32'hFFF0);
        repeat (8) cyc();
        chk("t2_p", 32'(pdrv_en), 32'h3);
        chk("t2_n", 32'(ndrv_enb), 32'hFFC0);
        chk("t2_weak", 32'({weak_pulldownen, weak_pullupenb}), 32'h1);
        wait_ack("t2_ack", 20);
        chk("t2_pf", 32'(pdrv_en), 32'h3);
        chk("t2_nf", 32'(ndrv_enb), 32'hFFC0);
        cyc();

        // Strengths saturate at 16.
        req(2'b11, 5'd31, 5'd20, 4'd0);
        cyc();
        cfg_req = 1'b0;
        wait_ack("t3_ack", 60);
        chk("t3_p", 32'(pdrv_en), 32'hFFFF);
        chk("t3_n", 32'(ndrv_enb), 32'h0000);
        cyc();

        // Drive to weak pullup: drain both legs, then switch the weak code.
        req(2'b10, 5'd9, 5'd9, 4'd1);
        cyc();
        cfg_req = 1'b0;
        wait_ack("t4_ack", 100);
        chk("t4_p", 32'(pdrv_en), 32'h0);
        chk("t4_n", 32'(ndrv_enb), 32'hFFFF);
        chk("t4_weak", 32'({weak_pulldownen, weak_pullupenb}), 32'h0);
        cyc();

        // Inputs wiggled while busy are ignored; a request held through DONE is taken next.
        req(2'b11, 5'd5, 5'd5, 4'd0);
        cyc();
        req(2'b01, 5'd9, 5'd9, 4'd7);
        cfg_req = 1'b0;
        cyc();
        cfg_req = 1'b1;
        cyc();
        cfg_req = 1'b0;
        cyc();
        cfg_req = 1'b1;
        wait_ack("t5_ack", 40);
        chk("t5_p", 32'(pdrv_en), 32'h1F);
        chk("t5_n", 32'(ndrv_enb), 32'hFFE0);
        cyc();
        chk("t5_idle", 32'(busy), 32'd0);
        cyc();
        chk("t5_rebusy", 32'(busy), 32'd1);
        cfg_req = 1'b0;
        wait_ack("t5b_ack", 100);
        chk("t5b_p", 32'(pdrv_en), 32'h0);
        chk("t5b_weak", 32'({weak_pulldownen, weak_pullupenb}), 32'h3);
        cyc();

        // Asynchronous reset in the middle of RAMP2.
        req(2'b11, 5'd8, 5'd8, 4'd1);
        cyc();
        cfg_req = 1'b0;
        repeat (9) cyc();
        chk("t6_p", 32'(pdrv_en), 32'h7);
        chk("t6_n", 32'(ndrv_enb), 32'hFFF8);
        #2 rstb = 1'b0;
        #1;
        chk("t6_rp", 32'(pdrv_en), 32'h0);
        chk("t6_rn", 32'(ndrv_enb), 32'hFFFF);
        chk("t6_rwk", 32'({weak_pulldownen, weak_pullupenb}), 32'h3);
        chk("t6_rba", 32'({busy, cfg_ack}), 32'h0);
        repeat (2) cyc();
        chk("t6_nack", 32'(n_ack), 32'd6);
        rstb = 1'b1;
        req(2'b00, 5'd0, 5'd0, 4'd0);
        cyc();
        chk("t7_busy", 32'(busy), 32'd1);
        cfg_req = 1'b0;
        wait_ack("t7_ack", 20);
        chk("t7_weak", 32'({weak_pulldownen, weak_pullupenb}), 32'h1);
        cyc();
        chk("t7_nack", 32'(n_ack), 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/aibnd_txdrv_seq.md
AIBND_TXDRV_SEQ -- requirements
Module: aibnd_txdrv_seq

Interface
REQ-001 The block SHALL have parameter NSEG, default 16, the number of driver segments per leg.
REQ-002 The block SHALL have port clk, input, 1, the sequencing clock.
REQ-003 The block SHALL have port rstb, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port cfg_req, input, 1, level request to apply a new configuration.
REQ-005 The block SHALL have port cfg_mode, input, 2, requested pad mode: 00 hi-Z, 01 weak pulldown, 10 weak pullup, 11 strong drive.
REQ-006 The block SHALL have port cfg_pstr, input, 5, requested count of enabled pull-up segments.
REQ-007 The block SHALL have port cfg_nstr, input, 5, requested count of enabled pull-down segments.
REQ-008 The block SHALL have port step_div, input, 4, segment step interval in cycles minus 1.
REQ-009 The block SHALL have port pdrv_en, output, NSEG, thermometer pull-up enables, active high.
REQ-010 The block SHALL have port ndrv_enb, output, NSEG, thermometer pull-down enables, active low.
REQ-011 The block SHALL have port weak_pulldownen, output, 1, weak-pull control bit.
REQ-012 The block SHALL have port weak_pullupenb, output, 1, weak-pull control bit, active low.
REQ-013 The block SHALL have port busy, output, 1, high while a sequence is in progress.
REQ-014 The block SHALL have port cfg_ack, output, 1, one-cycle pulse when a sequence completes.

Function
REQ-015 The weak-pull code SHALL be pulldown {pden=1, puenb=1}, pullup {0,0} and hi-Z {0,1}; code {1,0} SHALL never be driven.
REQ-016 pdrv_en SHALL be thermometer coded: bits [pcnt-1:0] set and all others 0.
REQ-017 ndrv_enb SHALL be the inverse of the thermometer code of ncnt.
REQ-018 Strength inputs above NSEG SHALL saturate to NSEG when captured.
REQ-019 When the captured mode is not 11, target strengths SHALL be forced to 0.
REQ-020 The FSM SHALL have exactly five states: IDLE, RAMP1, WEAK, RAMP2, DONE.
REQ-021 In IDLE with cfg_req=1, the block SHALL capture cfg_mode, cfg_pstr, cfg_nstr and step_div, set busy, and enter RAMP1 on the next cycle.
REQ-022 cfg_req and config changes while busy=1 SHALL be ignored.
REQ-023 A step tick SHALL occur every step_div+1 cycles while in RAMP1, WEAK or RAMP2.
REQ-024 The step counter SHALL restart at each state entry.
REQ-025 RAMP1 SHALL use the final target if both the current and new modes are 11, and 0 otherwise.
REQ-026 In RAMP1, on each tick pcnt and ncnt SHALL each move one step toward the RAMP1 target, independently.
REQ-027 RAMP1 SHALL exit to WEAK on the cycle both counts equal the RAMP1 target, including the case where they already match on entry.
REQ-028 On entry to WEAK, the weak code SHALL be set to the new mode's code, or hi-Z if the new mode is 11.
REQ-029 The block SHALL remain in WEAK for exactly one tick and then enter RAMP2.
REQ-030 RAMP2 SHALL ramp pcnt and ncnt toward the final targets, one segment per tick.
REQ-031 RAMP2 SHALL exit to DONE when both counts equal the final targets.
REQ-032 Break-before-make: a weak code other than hi-Z SHALL never coexist with pcnt>0 or ncnt>0.
REQ-033 Per tick, no count SHALL change by more than 1.
REQ-034 DONE SHALL last 1 cycle with cfg_ack=1, then return to IDLE with busy=0.
REQ-035 A request held high through DONE SHALL start a new sequence on the first IDLE cycle.

Reset
REQ-036 While rstb=0, outputs SHALL be asynchronously forced to: pdrv_en=0, ndrv_enb=all ones, weak code pulldown {1,0→1}, i.e. weak_pulldownen=1 and weak_pullupenb=1, busy=0, cfg_ack=0.
REQ-037 Reset SHALL force the FSM to IDLE and set the current mode to 01.
REQ-038 Reset asserted mid-sequence SHALL abort the sequence, with no cfg_ack issued.
REQ-039 After reset release, the first request SHALL be accepted on the first clk edge with rstb=1.

Verification
REQ-040 Reset release, then a request of {mode=11, pstr=4, nstr=3, step_div=0}: weak goes hi-Z in WEAK; pdrv_en steps 0x1, 0x3, 0x7, 0xF on consecutive cycles; ndrv_enb ends at 0xFFF8; cfg_ack fires once.
REQ-041 From drive {4,3}, a request of {11, 2, 6} with step_div=3: direct ramp with counts changing every 4 cycles; weak stays hi-Z throughout; final pdrv_en=0x3 and ndrv_enb=0xFFC0.
REQ-042 From drive {16,16}, a request for mode 10: both legs ramp to 0, then weak={0,0}; at no cycle is pcnt>0 while the weak code is not hi-Z.
REQ-043 A request of {11, 31, 20}: counts saturate at 16, giving pdrv_en=0xFFFF and ndrv_enb=0x0000.
REQ-044 While busy, toggle cfg_req and change cfg_*: the active sequence is unaffected; a request still high at DONE is accepted next.
REQ-045 Assert rstb=0 mid-RAMP2: outputs take reset values immediately with no cfg_ack; an assertion checks REQ-032 and REQ-033 on every cycle of all tests.
